// File: rtl/fetch_queue.sv
// In-order PC/instruction buffer between IF and ID.
// Gives IF backpressure through PC_write and drops all buffered wrong-path entries on a taken branch.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  PC_IF,
    input  logic [31:0]                  INSTRUCTION_IF,
    input  logic                         PCSrc,
    input  logic                         id_ready,
    output logic                         PC_write,
    output logic [31:0]                  PC_ID,
    output logic [31:0]                  INSTRUCTION_ID,
    output logic                         id_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic full;
    logic deq;
    logic enq;

    // Handshake decode; a redirect always lets IF load the branch target.
    always_comb begin
        id_valid = (count != '0);
        full     = (count == CNT_W'(DEPTH));
        deq      = id_valid & id_ready & ~PCSrc;
        PC_write = PCSrc | ~full | deq;
        enq      = PC_write & ~PCSrc;
    end

    // Pointers and count; a redirect empties the queue without consuming the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (PCSrc) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents are meaningless until covered by count.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            pc_mem[wr_ptr]    <= PC_IF;
            instr_mem[wr_ptr] <= INSTRUCTION_IF;
        end
    end

    // Head presentation; an empty queue shows a NOP at PC 0.
    always_comb begin
        PC_ID          = '0;
        INSTRUCTION_ID = NOP_INSTR;
        if (id_valid) begin
            PC_ID          = pc_mem[rd_ptr];
            INSTRUCTION_ID = instr_mem[rd_ptr];
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based model of the buffer and a simple IF PC model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC_IF = '0;
    logic [31:0] INSTRUCTION_IF = '0;
    logic        PCSrc = 1'b0;
    logic        id_ready = 1'b0;
    logic        PC_write;
    logic [31:0] PC_ID;
    logic [31:0] INSTRUCTION_ID;
    logic        id_valid;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .PC_IF(PC_IF), .INSTRUCTION_IF(INSTRUCTION_IF),
        .PCSrc(PCSrc), .id_ready(id_ready), .PC_write(PC_write), .PC_ID(PC_ID),
        .INSTRUCTION_ID(INSTRUCTION_ID), .id_valid(id_valid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    bit          armed = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] fetch_pc = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then apply enqueue/flush/reset to the model at the edge.
    task automatic cycle(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
        int sz;
        bit w_deq, w_pcw, w_enq;
        logic [31:0] old_pc;
        reset    = r;
        PCSrc    = s;
        id_ready = rd;
        sz    = exp_q.size();
        w_deq = (sz > 0) && rd && !s;
        w_pcw = s || (sz < int'(DEPTH)) || w_deq;
        w_enq = !r && w_pcw && !s;
        @(posedge clk);
        if (r || s) exp_q.delete();
        else if (w_enq) exp_q.push_back({PC_IF, INSTRUCTION_IF});
        if (r) armed = 1'b1;
        old_pc = fetch_pc;
        if (r)          fetch_pc = '0;
        else if (s)     fetch_pc = tgt;
        else if (w_pcw) fetch_pc = fetch_pc + 32'd4;
        #1;
        if (fetch_pc != old_pc || r) INSTRUCTION_IF = $urandom;
        PC_IF = fetch_pc;
    endtask

    // Monitor: mid-cycle, compare DUT head/status with the model and retire accepted entries.
    always @(negedge clk) begin
        int sz;
        logic [63:0] hd;
        bit exp_pcw;
        if (armed) begin
            sz = exp_q.size();
            exp_pcw = PCSrc || (sz < int'(DEPTH)) || ((sz > 0) && id_ready && !PCSrc);
            chk("occupancy", 32'(occupancy), 32'(sz));
            chk("id_valid", 32'(id_valid), 32'(sz != 0));
            chk("pc_write", 32'(PC_write), 32'(exp_pcw));
            if (sz > 0) begin
                hd = exp_q[0];
                chk("pc_id", PC_ID, hd[63:32]);
                chk("instr_id", INSTRUCTION_ID, hd[31:0]);
                if (id_ready && !PCSrc && !reset) void'(exp_q.pop_front());
            end else begin
                chk("pc_id_empty", PC_ID, 32'h0);
                chk("instr_id_empty", INSTRUCTION_ID, NOP);
            end
        end
    end

    initial begin
        INSTRUCTION_IF = $urandom;
        // reset, then free-running sequential fetch
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
        // fill under backpressure, then a single accept while full
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        // flush while full and stalled
        cycle(0, 1, 0, 32'h100);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        // branch flush with three entries queued
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 32'h100);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        // alternating ready across pointer wrap
        for (int i = 0; i < 20; i++) cycle(0, 0, 1'(i % 2 == 0), 0);
        // reset mid-operation with redirect and ready
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 32'h200);
        cycle(0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)),
                  {16'h0, 16'($urandom) & 16'hFFFC});
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction buffer between the IF stage and the ID stage of the 5-stage RISC-V pipeline.
- Captures each fetched PC/instruction pair and presents it in order to ID with a valid/ready handshake.
- Drives PC_write back into IF as backpressure.
- Flushes all buffered wrong-path instructions when a taken branch (PCSrc) is signalled.

Parameters:
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction word presented to ID when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PC_IF  input  32  PC of the instruction currently fetched by IF.
- INSTRUCTION_IF  input  32  instruction word at PC_IF; combinationally valid every cycle.
- PCSrc  input  1  taken-branch/redirect this cycle; same signal that steers the IF PC mux.
- id_ready  input  1  ID stage accepts the head entry this cycle (IF/ID write enable).
- PC_write  output  1  PC update enable to IF; combinational.
- PC_ID  output  32  PC of head entry.
- INSTRUCTION_ID  output  32  instruction of head entry.
- id_valid  output  1  head entry is valid.
- occupancy  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {pc[31:0], instr[31:0]}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - count ranges 0..DEPTH.
- Reset (synchronous, reset=1 at a rising edge):
  - count=0, pointers=0.
  - Outputs after reset: id_valid=0, occupancy=0, PC_ID=32'h0, INSTRUCTION_ID=NOP_INSTR.
  - PC_write=1 combinationally, because the queue is empty.
  - reset overrides PCSrc, enqueue and dequeue.
  - reset mid-operation discards all entries.
- Derived signals:
  - deq = id_valid & id_ready & ~PCSrc
  - full = (count==DEPTH)
  - PC_write = PCSrc | ~full | deq
  - enq = PC_write & ~PCSrc
- PCSrc forces PC_write=1 so IF always loads PC_Branch, even when the queue is full.
- Enqueue: on enq, the pair {PC_IF, INSTRUCTION_IF} is written at the write pointer and the write pointer increments.
  - Write when full is legal only together with deq, in the same cycle.
- Dequeue: on deq, the read pointer increments.
  - Simultaneous enq and deq leaves count unchanged.
- Flush: when PCSrc=1 and reset=0 at an edge:
  - count=0 and read pointer = write pointer.
  - The instruction fetched this cycle is wrong-path and is not written.
  - No dequeue is counted; ID is expected to squash its own register on PCSrc.
  - The first entry after a flush is the branch target, fetched in the next cycle.
- Latency: an instruction fetched in cycle N is visible on PC_ID/INSTRUCTION_ID with id_valid=1 in cycle N+1 at the earliest. There is no bypass.
- Head outputs:
  - Registered storage read combinationally at the read pointer.
  - When count==0: id_valid=0, PC_ID=0, INSTRUCTION_ID=NOP_INSTR.
- Head stability: while id_valid=1 and id_ready=0 and PCSrc=0, PC_ID/INSTRUCTION_ID hold their values.
- occupancy = count, registered.
- Invariants (assertable):
  - count never exceeds DEPTH.
  - count never underflows.
  - PC_write=0 only when full & ~deq & ~PCSrc.

Test Plan:
- Reset then free-run:
  - Stimulus: reset=1 for 2 cycles, then id_ready=1, IF sequential from PC 0x0.
  - Response: id_valid rises one cycle after reset deasserts; PC_ID sequence 0x0, 0x4, 0x8…; occupancy stays 1; PC_write constantly 1.
- Fill and backpressure:
  - Stimulus: id_ready=0 from reset, DEPTH=4.
  - Response: occupancy 1,2,3,4 over four cycles; PC_write=0 once occupancy=4; PC_ID holds 0x0.
  - Then id_ready=1 for one cycle: PC_write=1 that cycle, the entry for PC 0x10 is written, occupancy remains 4, PC_ID becomes 0x4.
- Branch flush:
  - Stimulus: with 3 entries (PCs 0x20, 0x24, 0x28) queued, assert PCSrc for one cycle while IF presents PC 0x2C; IF then fetches 0x100.
  - Response: next cycle occupancy=0 and id_valid=0; the following cycle PC_ID=0x100; 0x2C is never presented.
- Flush while full and stalled:
  - Stimulus: occupancy=4, id_ready=0, PCSrc=1.
  - Response: PC_write=1 during the PCSrc cycle; the queue empties.
- Wrap-around:
  - Stimulus: alternate id_ready 1/0 for 20 cycles with continuous fetch.
  - Response: the PC_ID stream is strictly PC_IF order with no duplicates or skips across pointer wrap; a scoreboard matches every instruction word.
- Reset mid-operation:
  - Stimulus: occupancy=3, assert reset together with PCSrc=1 and id_ready=1.
  - Response: next cycle occupancy=0, INSTRUCTION_ID=32'h00000013, PC_ID=0.
